axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3 responder (slave) backed by an on-chip word-addressed SRAM.
- It is the other end of the channel the cache bypass/refill masters drive: it accepts AR/AW/W, returns R/B, and echoes IDs.
- It serves as the simulation memory model and FPGA scratch memory for cache and uncached-path bring-up.
- One transaction in flight at a time; single transfers and INCR/FIXED bursts up to 16 beats.

Parameters:
- BUS_WIDTH, 4, width of AXI ID fields (arid/awid/wid/rid/bid).
- DATA_WIDTH, 32, AXI data width; bytes per beat = DATA_WIDTH/8 (fixed 4).
- MEM_WORDS, 1024, SRAM depth in DATA_WIDTH words; must be a power of two.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- axi_req  input  axi_req_t  master request channels: AR, AW, W, rready, bready.
- axi_req_arid  input  BUS_WIDTH  read address ID.
- axi_req_awid  input  BUS_WIDTH  write address ID.
- axi_req_wid  input  BUS_WIDTH  write data ID; ignored.
- axi_resp  output  axi_resp_t  arready, awready, wready, rvalid, rdata, rresp, rlast, bvalid, bresp.
- axi_resp_rid  output  BUS_WIDTH  read data ID, equal to the latched arid.
- axi_resp_bid  output  BUS_WIDTH  write response ID, equal to the latched awid.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). It forces state=IDLE, all valid/ready outputs low except arready/awready, beat counters 0, rid/bid 0. SRAM contents are not reset.
- States: IDLE, RD_FETCH, RD_BURST, WR_DATA, WR_RESP.
- IDLE: arready=1 and awready=1 combinationally from state.
  - arvalid: latch araddr, arlen (4 bits, beats=arlen+1), arburst, arid; go to RD_FETCH.
  - else awvalid: latch awaddr, awlen, awburst, awid; go to WR_DATA.
  - Both valid in the same cycle: read wins. awready is driven 0 that cycle, so the AW handshake does not occur.
- Word index = addr[2 +: log2(MEM_WORDS)]. Upper address bits alias; no error response is generated. rresp and bresp are always 2'b00 (OKAY).
- arsize/awsize are ignored; every beat is 4 bytes.
- Address step per beat: burst 2'b01 (INCR) adds 1 word, wrapping modulo MEM_WORDS. 2'b00 (FIXED) keeps the address. 2'b10 (WRAP) is treated as INCR.
- RD_FETCH: issue the synchronous SRAM read at the current index; go to RD_BURST next cycle. The SRAM read is registered.
- RD_BURST:
  - rvalid=1; rdata is the registered SRAM output; rid is the latched arid; rlast=1 iff beat_cnt==arlen.
  - rvalid and rdata stay stable until rready.
  - On rvalid&rready: if rlast, go to IDLE; else increment beat_cnt, advance the address, and return to RD_FETCH.
  - Throughput is therefore 1 beat per 2 cycles.
  - Latency from AR handshake to first rvalid is 2 cycles.
- WR_DATA:
  - wready=1. On wvalid, write wdata to SRAM at the current index under wstrb; bytes with a 0 strobe bit are kept.
  - The beat count governs completion. After beat arlen/awlen+1, i.e. beat_cnt==awlen, go to WR_RESP.
  - wlast is not checked. An early or late wlast does not change the beat count.
- WR_RESP: bvalid=1, bid is the latched awid. On bready, go to IDLE.
- A single-beat write followed by a read of the same address returns the new data; the write has committed before WR_RESP.
- rst asserted mid-burst: the next cycle is IDLE with valids low. SRAM writes already committed remain; the current beat's write still commits if wvalid&wready in that same cycle.
- Unused outputs are driven 0 when idle (rlast, rdata=0 outside RD_BURST).

Decomposition:
- axi_req_t/axi_resp_t and AXI burst/resp encodings (BURST_FIXED/INCR/WRAP, RESP_OKAY) live in the shared common definitions package.
- The state enum is local to the module.
- One sub-module, sram_1rw: single-port RAM with byte-write enables, registered read, parameterised by depth and width, no reset.

Test Plan:
- Single write then read: AW addr 0x100, awlen 0, wdata 0xDEADBEEF, wstrb 4'b1111 → B with bid=awid, bresp 0. Then AR 0x100, arlen 0, arid 5 → one R beat, rdata 0xDEADBEEF, rlast 1, rid 5, first rvalid 2 cycles after AR handshake.
- Partial strobe: preload 0x11223344 at 0x40, write 0xAABBCCDD with wstrb 4'b0101 → readback 0x11BB33DD.
- INCR burst: 8-beat write at 0x200 with data i+1 → 8-beat read arlen 7 returns 1..8; rlast only on beat 8; rready toggled randomly, and data holds while stalled.
- Wrap and FIXED: INCR 4-beat write starting at word MEM_WORDS-2 → words MEM_WORDS-2, MEM_WORDS-1, 0, 1 are written. FIXED 4-beat write at 0x80 → only 0x80 is updated, holding the last beat's data.
- Simultaneous arvalid and awvalid in IDLE → read served first, awready=0 that cycle; write is accepted after the read's last beat, and both complete with correct IDs.
- rst pulsed during beat 3 of an 8-beat read → next cycle rvalid=0 and state IDLE; a fresh read of the same address returns the unchanged data.

Source files
------------

// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI3 channel bundles and encodings for the SRAM-backed responder.
package axi_sram_slave_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [3:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [3:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [AXI_STRB_WIDTH-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      rready;
    logic                      bready;
  } axi_req_t;

  typedef struct packed {
    logic                      arready;
    logic                      awready;
    logic                      wready;
    logic                      rvalid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      bvalid;
    logic [1:0]                bresp;
  } axi_resp_t;

  // FIXED holds the address; INCR and WRAP (treated as INCR) step one word.
  function automatic logic burst_advances(input logic [1:0] burst);
    return burst != BURST_FIXED;
  endfunction

endpackage

// File: rtl/axi_sram_slave_sram_1rw.sv
// Single-port RAM with byte write enables and a registered read port; no reset.
module sram_1rw #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata only changes on a read, so it holds across write and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < int'(WIDTH / 8); i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a word-addressed SRAM; one transaction in flight,
// single beats and FIXED/INCR bursts of up to 16 beats.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  axi_req_t             axi_req,
  input  logic [BUS_WIDTH-1:0] axi_req_arid,
  input  logic [BUS_WIDTH-1:0] axi_req_awid,
  input  logic [BUS_WIDTH-1:0] axi_req_wid,
  output axi_resp_t            axi_resp,
  output logic [BUS_WIDTH-1:0] axi_resp_rid,
  output logic [BUS_WIDTH-1:0] axi_resp_bid
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {StIdle, StRdFetch, StRdBurst, StWrData, StWrResp} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [3:0]            beat_q, beat_d;
  logic [BUS_WIDTH-1:0]  rid_q, rid_d;
  logic [BUS_WIDTH-1:0]  bid_q, bid_d;

  logic                  ram_en, ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic unused_inputs;
  assign unused_inputs = ^{axi_req.araddr, axi_req.awaddr, axi_req.arsize, axi_req.awsize,
                           axi_req.wlast, axi_req_wid};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    rid_d    = rid_q;
    bid_d    = bid_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    axi_resp = '0;
    axi_resp.rresp = RESP_OKAY;
    axi_resp.bresp = RESP_OKAY;

    unique case (state_q)
      StIdle: begin
        axi_resp.arready = 1'b1;
        // Read wins a tie, so AW must not handshake in the same cycle.
        axi_resp.awready = ~axi_req.arvalid;
        if (axi_req.arvalid) begin
          addr_d  = axi_req.araddr[2 +: IdxW];
          len_d   = axi_req.arlen;
          burst_d = axi_req.arburst;
          rid_d   = axi_req_arid;
          beat_d  = 4'd0;
          state_d = StRdFetch;
        end else if (axi_req.awvalid) begin
          addr_d  = axi_req.awaddr[2 +: IdxW];
          len_d   = axi_req.awlen;
          burst_d = axi_req.awburst;
          bid_d   = axi_req_awid;
          beat_d  = 4'd0;
          state_d = StWrData;
        end
      end
      StRdFetch: begin
        ram_en  = 1'b1;
        state_d = StRdBurst;
      end
      StRdBurst: begin
        axi_resp.rvalid = 1'b1;
        axi_resp.rdata  = ram_rdata;
        axi_resp.rlast  = (beat_q == len_q);
        if (axi_req.rready) begin
          if (beat_q == len_q) begin
            beat_d  = 4'd0;
            state_d = StIdle;
          end else begin
            beat_d  = beat_q + 4'd1;
            if (burst_advances(burst_q)) addr_d = addr_q + 1'b1;
            state_d = StRdFetch;
          end
        end
      end
      StWrData: begin
        axi_resp.wready = 1'b1;
        if (axi_req.wvalid) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
          // Completion follows the beat count; wlast is deliberately ignored.
          if (beat_q == len_q) begin
            beat_d  = 4'd0;
            state_d = StWrResp;
          end else begin
            beat_d = beat_q + 4'd1;
            if (burst_advances(burst_q)) addr_d = addr_q + 1'b1;
          end
        end
      end
      StWrResp: begin
        axi_resp.bvalid = 1'b1;
        if (axi_req.bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= BURST_FIXED;
      beat_q  <= '0;
      rid_q   <= '0;
      bid_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      rid_q   <= rid_d;
      bid_q   <= bid_d;
    end
  end

  assign axi_resp_rid = rid_q;
  assign axi_resp_bid = bid_q;

  // Write enable is independent of rst so a beat accepted in the reset cycle still lands.
  sram_1rw #(
    .DEPTH(MEM_WORDS),
    .WIDTH(DATA_WIDTH)
  ) u_sram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (axi_req.wstrb),
    .addr (addr_q),
    .wdata(axi_req.wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus pushes expected R/B responses,
// a negedge monitor pops and compares them at each handshake.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  localparam int unsigned MEM_WORDS = 1024;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } r_item_t;

  logic       clk = 1'b0;
  logic       rst;
  axi_req_t   req;
  axi_resp_t  resp;
  logic [3:0] arid, awid, wid;
  logic [3:0] rid, bid;

  r_item_t    r_exp[$];
  logic [3:0] b_exp[$];
  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  axi_sram_slave #(
    .BUS_WIDTH (4),
    .DATA_WIDTH(32),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .axi_req     (req),
    .axi_req_arid(arid),
    .axi_req_awid(awid),
    .axi_req_wid (wid),
    .axi_resp    (resp),
    .axi_resp_rid(rid),
    .axi_resp_bid(bid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    cmp_cnt++;
    fail_cnt++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: handshakes complete at the next posedge, so compare at the negedge before it.
  bit          stall_q = 1'b0;
  logic [31:0] hold_q;
  always @(negedge clk) begin
    r_item_t ri;
    if (resp.rvalid) begin
      if (stall_q) chk("rdata_hold", resp.rdata, hold_q);
      if (req.rready) begin
        if (r_exp.size() == 0) begin
          timeout("unexpected_r_beat");
        end else begin
          ri = r_exp.pop_front();
          chk("rdata", resp.rdata, ri.data);
          chk("rid", 32'(rid), 32'(ri.id));
          chk("rlast", 32'(resp.rlast), 32'(ri.last));
          chk("rresp", 32'(resp.rresp), 32'(RESP_OKAY));
        end
      end
      stall_q = !req.rready;
      hold_q  = resp.rdata;
    end else begin
      stall_q = 1'b0;
    end
    if (resp.bvalid && req.bready) begin
      if (b_exp.size() == 0) begin
        timeout("unexpected_b");
      end else begin
        chk("bid", 32'(bid), 32'(b_exp.pop_front()));
        chk("bresp", 32'(resp.bresp), 32'(RESP_OKAY));
      end
    end
  end

  // All drive tasks start and end at posedge+#1.
  task automatic send_ar(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                         input logic [3:0] id);
    bit done = 0;
    int n = 0;
    req.araddr = a; req.arlen = l; req.arburst = b; req.arsize = 3'd2; arid = id;
    req.arvalid = 1'b1;
    while (!done) begin
      @(negedge clk); done = resp.arready;
      @(posedge clk); #1;
      if (!done && ++n > 100) begin timeout("ar_handshake"); done = 1; end
    end
    req.arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                         input logic [3:0] id);
    bit done = 0;
    int n = 0;
    req.awaddr = a; req.awlen = l; req.awburst = b; req.awsize = 3'd2; awid = id;
    req.awvalid = 1'b1;
    while (!done) begin
      @(negedge clk); done = resp.awready;
      @(posedge clk); #1;
      if (!done && ++n > 100) begin timeout("aw_handshake"); done = 1; end
    end
    req.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    bit done = 0;
    int n = 0;
    req.wdata = d; req.wstrb = s; req.wlast = last; wid = awid;
    req.wvalid = 1'b1;
    while (!done) begin
      @(negedge clk); done = resp.wready;
      @(posedge clk); #1;
      if (!done && ++n > 100) begin timeout("w_handshake"); done = 1; end
    end
    req.wvalid = 1'b0;
    req.wlast  = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while (1) begin
      @(posedge clk); #1;
      if (rnd) req.rready = 1'($urandom_range(0, 1));
      if (r_exp.size() == 0 && b_exp.size() == 0) break;
      if (++n > 300) begin
        timeout("drain");
        r_exp.delete();
        b_exp.delete();
        break;
      end
    end
    req.rready = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                          input logic [3:0] id, input logic [3:0] s);
    b_exp.push_back(id);
    send_aw(a, l, b, id);
    for (int i = 0; i <= int'(l); i++) send_w(wbuf[i], s, i == int'(l));
    drain(1'b0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                         input logic [3:0] id, input bit rnd);
    for (int i = 0; i <= int'(l); i++) r_exp.push_back('{rbuf[i], id, i == int'(l)});
    send_ar(a, l, b, id);
    drain(rnd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit done;
    int n;
    rst = 1'b1;
    req = '0;
    req.rready = 1'b1;
    req.bready = 1'b1;
    arid = '0; awid = '0; wid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_arready", 32'(resp.arready), 32'd1);
    chk("rst_awready", 32'(resp.awready), 32'd1);
    chk("rst_rvalid", 32'(resp.rvalid), 32'd0);
    chk("rst_wready", 32'(resp.wready), 32'd0);
    chk("rst_bvalid", 32'(resp.bvalid), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);

    // Single write then read, with first-beat latency
    wbuf[0] = 32'hDEADBEEF;
    do_write(32'h100, 4'd0, BURST_INCR, 4'd7, 4'b1111);
    r_exp.push_back('{32'hDEADBEEF, 4'd5, 1'b1});
    send_ar(32'h100, 4'd0, BURST_INCR, 4'd5);
    chk("lat_cycle1_rvalid", 32'(resp.rvalid), 32'd0);
    @(posedge clk); #1;
    chk("lat_cycle2_rvalid", 32'(resp.rvalid), 32'd1);
    drain(1'b0);
    chk("idle_rdata_zero", resp.rdata, 32'd0);

    // Partial strobe
    wbuf[0] = 32'h11223344;
    do_write(32'h40, 4'd0, BURST_INCR, 4'd1, 4'b1111);
    wbuf[0] = 32'hAABBCCDD;
    do_write(32'h40, 4'd0, BURST_INCR, 4'd2, 4'b0101);
    rbuf[0] = 32'h11BB33DD;
    do_read(32'h40, 4'd0, BURST_INCR, 4'd3, 1'b0);

    // 8-beat INCR burst, random rready on readback
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'(i + 1); rbuf[i] = 32'(i + 1); end
    do_write(32'h200, 4'd7, BURST_INCR, 4'd4, 4'b1111);
    do_read(32'h200, 4'd7, BURST_INCR, 4'd6, 1'b1);

    // INCR wrap at the top of memory: words 1022, 1023, 0, 1
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); rbuf[i] = 32'hA0 + 32'(i); end
    do_write(32'((MEM_WORDS - 2) * 4), 4'd3, BURST_INCR, 4'd8, 4'b1111);
    do_read(32'((MEM_WORDS - 2) * 4), 4'd3, BURST_INCR, 4'd9, 1'b0);
    rbuf[0] = 32'hA2;
    do_read(32'h0, 4'd0, BURST_INCR, 4'd10, 1'b0);
    rbuf[0] = 32'hA3;
    do_read(32'h4, 4'd0, BURST_INCR, 4'd11, 1'b0);

    // FIXED burst updates only its one word
    wbuf[0] = 32'h55555555;
    do_write(32'h84, 4'd0, BURST_INCR, 4'd12, 4'b1111);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + 32'(i);
    do_write(32'h80, 4'd3, BURST_FIXED, 4'd13, 4'b1111);
    rbuf[0] = 32'hB3;
    do_read(32'h80, 4'd0, BURST_INCR, 4'd14, 1'b0);
    rbuf[0] = 32'h55555555;
    do_read(32'h84, 4'd0, BURST_INCR, 4'd15, 1'b0);
    rbuf[0] = 32'hB3; rbuf[1] = 32'hB3;
    do_read(32'h80, 4'd1, BURST_FIXED, 4'd1, 1'b0);

    // Simultaneous AR and AW: read first, AW held off until the read ends
    r_exp.push_back('{32'hDEADBEEF, 4'd9, 1'b1});
    b_exp.push_back(4'hA);
    req.araddr = 32'h100; req.arlen = 4'd0; req.arburst = BURST_INCR; arid = 4'd9;
    req.awaddr = 32'h300; req.awlen = 4'd0; req.awburst = BURST_INCR; awid = 4'hA;
    req.arvalid = 1'b1; req.awvalid = 1'b1;
    @(negedge clk);
    chk("tie_arready", 32'(resp.arready), 32'd1);
    chk("tie_awready", 32'(resp.awready), 32'd0);
    @(posedge clk); #1;
    req.arvalid = 1'b0;
    done = 0; n = 0;
    while (!done) begin
      @(negedge clk);
      if (resp.awready) begin
        chk("aw_after_read_pending_r", 32'(r_exp.size()), 32'd0);
        done = 1;
      end
      @(posedge clk); #1;
      if (!done && ++n > 100) begin timeout("tie_aw"); done = 1; end
    end
    req.awvalid = 1'b0;
    send_w(32'h12345678, 4'b1111, 1'b1);
    drain(1'b0);
    rbuf[0] = 32'h12345678;
    do_read(32'h300, 4'd0, BURST_INCR, 4'd2, 1'b0);

    // Reset during beat 3 of an 8-beat read
    r_exp.push_back('{32'd1, 4'd3, 1'b0});
    r_exp.push_back('{32'd2, 4'd3, 1'b0});
    send_ar(32'h200, 4'd7, BURST_INCR, 4'd3);
    n = 0;
    while (r_exp.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    if (r_exp.size() != 0) timeout("rst_first_beats");
    req.rready = 1'b0;
    n = 0;
    while (!resp.rvalid && n < 100) begin @(posedge clk); #1; n++; end
    chk("beat3_rdata", resp.rdata, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_rvalid", 32'(resp.rvalid), 32'd0);
    chk("midrst_rlast", 32'(resp.rlast), 32'd0);
    chk("midrst_arready", 32'(resp.arready), 32'd1);
    chk("midrst_rid", 32'(rid), 32'd0);
    req.rready = 1'b1;
    for (int i = 0; i < 8; i++) rbuf[i] = 32'(i + 1);
    do_read(32'h200, 4'd7, BURST_INCR, 4'd4, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
